cam_dvp_emulator: RTL and testbench

- DVP camera-side transmitter: generates PCLK-synchronous VSYNC/HREF/8-bit data with OV-style frame timing and synthetic test patterns.
- Drives the camera capture path in simulation and on-board bring-up, replacing the sensor. Output is byte-exact with what the capture side expects: RGB565 high byte first, or one raw byte per pixel.
- Fully synchronous to the pixel clock it is given.

---
 rtl/cam_dvp_emulator.sv | 202 ++++++++++++++++++++
 tb/tb_cam_dvp_emulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_dvp_emulator.sv
`default_nettype none
// ============================================================================
// Module : cam_dvp_emulator
// Brief  : DVP camera-side transmitter producing OV-style VSYNC/HREF/data
//          timing with synthetic test patterns. Define CAM_EMU_FRAME_STAMP_EN
//          to replace pixel (0,0) of every frame with frame_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module cam_dvp_emulator #(
    parameter int COLOR_MODE = 1,
    parameter int IM_X       = 1280,
    parameter int IM_Y       = 720,
    parameter int H_BLANK    = 144,
    parameter int VSYNC_LEN  = 3,
    parameter int V_BACK     = 17,
    parameter int V_FRONT    = 10
) (
    input  logic        pclk,
    input  logic        rst_n_cam,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        VSYNC_cam,
    output logic        HREF_cam,
    output logic [7:0]  data_cam,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int C_BPP       = (COLOR_MODE == 1) ? 2 : 1;
    localparam int C_ACT_BYTES = IM_X * C_BPP;
    localparam int C_LP        = C_ACT_BYTES + H_BLANK;
    localparam int C_BW        = $clog2(C_LP);
    localparam int C_MAX_A     = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int C_MAX_B     = (IM_Y > V_FRONT) ? IM_Y : V_FRONT;
    localparam int C_MAX_L     = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int C_LW        = $clog2(C_MAX_L + 1);

    localparam logic [C_BW-1:0] C_LP_LAST  = C_BW'(C_LP - 1);
    localparam logic [C_BW-1:0] C_ACT_N    = C_BW'(C_ACT_BYTES);
    localparam logic [C_BW-1:0] C_BAR_W    = C_BW'(IM_X / 8);
    localparam logic [C_BW-1:0] C_BYTE_ONE = C_BW'(1);
    localparam logic [C_LW-1:0] C_LINE_ONE = C_LW'(1);
    localparam logic [C_LW-1:0] C_VS_LAST  = C_LW'(VSYNC_LEN - 1);
    localparam logic [C_LW-1:0] C_VB_LAST  = C_LW'(V_BACK - 1);
    localparam logic [C_LW-1:0] C_Y_LAST   = C_LW'(IM_Y - 1);
    localparam logic [C_LW-1:0] C_VF_LAST  = C_LW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t            r_state, w_state_nx;
    logic [C_BW-1:0]   r_byte, w_byte_nx;
    logic [C_LW-1:0]   r_line, w_line_nx;
    logic [C_LW-1:0]   w_line_last;
    logic              w_line_end;
    logic              w_latch;
    logic [1:0]        r_pat;

    logic              r_vsync, r_href, r_done;
    logic [7:0]        r_data;
    logic [15:0]       r_frame_cnt;

    logic [C_BW-1:0]   w_x;
    logic [7:0]        w_x8, w_y8;
    logic [2:0]        w_bar;
    logic [15:0]       w_pix;
    logic [7:0]        w_byte_val;
    logic              w_href, w_done;

    // State and counters describe the cycle currently on the pins; the
    // outputs are registered from the next position so they line up with it.
    always_comb begin
        w_state_nx  = r_state;
        w_byte_nx   = r_byte;
        w_line_nx   = r_line;
        w_latch     = 1'b0;
        w_line_end  = (r_byte == C_LP_LAST);
        w_line_last = C_VF_LAST;
        case (r_state)
            S_VSYNC:  w_line_last = C_VS_LAST;
            S_VBACK:  w_line_last = C_VB_LAST;
            S_ACTIVE: w_line_last = C_Y_LAST;
            default:  w_line_last = C_VF_LAST;
        endcase

        if (r_state == S_IDLE) begin
            if (enable) begin
                w_state_nx = S_VSYNC;
                w_byte_nx  = '0;
                w_line_nx  = '0;
                w_latch    = 1'b1;
            end
        end else if (!w_line_end) begin
            w_byte_nx = r_byte + C_BYTE_ONE;
        end else begin
            w_byte_nx = '0;
            if (r_line != w_line_last) begin
                w_line_nx = r_line + C_LINE_ONE;
            end else begin
                w_line_nx = '0;
                case (r_state)
                    S_VSYNC:  w_state_nx = S_VBACK;
                    S_VBACK:  w_state_nx = S_ACTIVE;
                    S_ACTIVE: w_state_nx = S_VFRONT;
                    default: begin
                        if (enable) begin
                            w_state_nx = S_VSYNC;
                            w_latch    = 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    generate
        if (C_BPP == 2) begin : g_bpp2
            assign w_x        = {1'b0, w_byte_nx[C_BW-1:1]};
            assign w_byte_val = w_byte_nx[0] ? w_pix[7:0] : w_pix[15:8];
        end else begin : g_bpp1
            assign w_x        = w_byte_nx;
            assign w_byte_val = w_pix[7:0];
        end
    endgenerate

    assign w_x8  = 8'(w_x);
    assign w_y8  = 8'(w_line_nx);
    assign w_bar = 3'(w_x / C_BAR_W);

    always_comb begin
        w_pix = 16'h0000;
        case (r_pat)
            2'd0: begin
                case (w_bar)
                    3'd0:    w_pix = 16'hFFFF;
                    3'd1:    w_pix = 16'hFFE0;
                    3'd2:    w_pix = 16'h07FF;
                    3'd3:    w_pix = 16'h07E0;
                    3'd4:    w_pix = 16'hF81F;
                    3'd5:    w_pix = 16'hF800;
                    3'd6:    w_pix = 16'h001F;
                    default: w_pix = 16'h0000;
                endcase
            end
            2'd1:    w_pix = {w_x8[7:3], w_x8[7:2], w_x8[7:3]};
            2'd2:    w_pix = {w_y8, w_x8};
            default: w_pix = (w_x8[3] ^ w_y8[3]) ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CAM_EMU_FRAME_STAMP_EN
        if ((w_x == '0) && (w_line_nx == '0)) begin
            w_pix = r_frame_cnt;
        end
`endif
    end

    assign w_href = (w_state_nx == S_ACTIVE) && (w_byte_nx < C_ACT_N);
    assign w_done = (w_state_nx == S_VFRONT) && (w_line_nx == C_VF_LAST)
                    && (w_byte_nx == C_LP_LAST);

    always_ff @(posedge pclk or negedge rst_n_cam) begin
        if (!rst_n_cam) begin
            r_state     <= S_IDLE;
            r_byte      <= '0;
            r_line      <= '0;
            r_pat       <= 2'd0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= 8'h00;
            r_done      <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nx;
            r_byte  <= w_byte_nx;
            r_line  <= w_line_nx;
            if (w_latch) begin
                r_pat <= pattern_sel;
            end
            r_vsync <= (w_state_nx == S_VSYNC);
            r_href  <= w_href;
            r_data  <= w_href ? w_byte_val : 8'h00;
            r_done  <= w_done;
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign VSYNC_cam  = r_vsync;
    assign HREF_cam   = r_href;
    assign data_cam   = r_data;
    assign frame_done = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cam_dvp_emulator.sv
`default_nettype none
// ============================================================================
// Module : tb_cam_dvp_emulator
// Brief  : Directed/randomised bench for cam_dvp_emulator with a frame-level
//          reference model; optional stamp checks under CAM_EMU_FRAME_STAMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cam_dvp_emulator;

    localparam int IM_X       = 8;
    localparam int IM_Y       = 4;
    localparam int H_BLANK    = 4;
    localparam int VSYNC_LEN  = 2;
    localparam int V_BACK     = 1;
    localparam int V_FRONT    = 1;
    localparam int COLOR_MODE = 1;
    localparam int BPP        = 2;
    localparam int LP         = IM_X * BPP + H_BLANK;
    localparam int FRAME      = (VSYNC_LEN + V_BACK + IM_Y + V_FRONT) * LP;

    localparam logic [7:0] BAR_LINE [16] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
        8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    logic        pclk        = 1'b0;
    logic        rst_n_cam   = 1'b0;
    logic        enable      = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        VSYNC_cam, HREF_cam, frame_done;
    logic [7:0]  data_cam;
    logic [15:0] frame_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  cap [IM_X*BPP];
    int          href_pulses, href_cycles;

    cam_dvp_emulator #(
        .COLOR_MODE (COLOR_MODE),
        .IM_X       (IM_X),
        .IM_Y       (IM_Y),
        .H_BLANK    (H_BLANK),
        .VSYNC_LEN  (VSYNC_LEN),
        .V_BACK     (V_BACK),
        .V_FRONT    (V_FRONT)
    ) dut (
        .pclk        (pclk),
        .rst_n_cam   (rst_n_cam),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .VSYNC_cam   (VSYNC_cam),
        .HREF_cam    (HREF_cam),
        .data_cam    (data_cam),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int p, input int x, input int y,
                                            input logic [15:0] cnt);
        int g;
        logic [15:0] pix;
        case (p)
            0: begin
                case (x / (IM_X / 8))
                    0: pix = 16'hFFFF;
                    1: pix = 16'hFFE0;
                    2: pix = 16'h07FF;
                    3: pix = 16'h07E0;
                    4: pix = 16'hF81F;
                    5: pix = 16'hF800;
                    6: pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            1: begin
                g   = x % 256;
                pix = 16'(((g / 8) * 2048) + ((g / 4) * 32) + (g / 8));
            end
            2: pix = 16'(((y % 256) * 256) + (x % 256));
            default: pix = ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CAM_EMU_FRAME_STAMP_EN
        if (x == 0 && y == 0) pix = cnt;
`else
        if (cnt == 16'hFFFF && x < 0) pix = 16'h0000;
`endif
        return pix;
    endfunction

    // Checks cycles 0..n_cyc-1 of a frame whose first cycle is on the pins now.
    task automatic run_frame(input int pat, input int n_cyc, input int drop_at,
                             input int chg_at, input logic [1:0] chg_val,
                             input logic [15:0] cnt_before);
        int line, b, y, x;
        logic e_vs, e_href, e_done, prev_href;
        logic [7:0]  e_data;
        logic [15:0] pix, e_cnt;
        href_pulses = 0;
        href_cycles = 0;
        prev_href   = 1'b0;
        for (int t = 0; t < n_cyc; t++) begin
            line   = t / LP;
            b      = t % LP;
            y      = line - (VSYNC_LEN + V_BACK);
            x      = b / BPP;
            e_vs   = (line < VSYNC_LEN);
            e_href = (y >= 0) && (y < IM_Y) && (b < IM_X * BPP);
            e_data = 8'h00;
            if (e_href) begin
                pix    = ref_pix(pat, x, y, cnt_before);
                e_data = (b % 2 == 0) ? pix[15:8] : pix[7:0];
            end
            e_done = (t == FRAME - 1);
            e_cnt  = e_done ? cnt_before + 16'd1 : cnt_before;
            check($sformatf("VSYNC_cam t=%0d", t), 16'(VSYNC_cam), 16'(e_vs));
            check($sformatf("HREF_cam t=%0d", t), 16'(HREF_cam), 16'(e_href));
            check($sformatf("data_cam t=%0d", t), 16'(data_cam), 16'(e_data));
            check($sformatf("frame_done t=%0d", t), 16'(frame_done), 16'(e_done));
            check($sformatf("frame_cnt t=%0d", t), frame_cnt, e_cnt);
            if (e_href && y == 0) cap[b] = data_cam;
            if (HREF_cam && !prev_href) href_pulses++;
            if (HREF_cam) href_cycles++;
            prev_href = HREF_cam;
            if (t == drop_at) enable = 1'b0;
            if (t == chg_at) pattern_sel = chg_val;
            if (t != n_cyc - 1) tick();
        end
    endtask

    task automatic check_idle(input int n, input logic [15:0] cnt);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle VSYNC_cam", 16'(VSYNC_cam), 16'd0);
            check("idle HREF_cam", 16'(HREF_cam), 16'd0);
            check("idle data_cam", 16'(data_cam), 16'd0);
            check("idle frame_done", 16'(frame_done), 16'd0);
            check("idle frame_cnt", frame_cnt, cnt);
        end
    endtask

    initial begin
        int p1, p2, p3, rs;

        // Reset state
        repeat (3) tick();
        check("rst VSYNC_cam", 16'(VSYNC_cam), 16'd0);
        check("rst HREF_cam", 16'(HREF_cam), 16'd0);
        check("rst data_cam", 16'(data_cam), 16'd0);
        check("rst frame_done", 16'(frame_done), 16'd0);
        check("rst frame_cnt", frame_cnt, 16'd0);
        rst_n_cam = 1'b1;
        check_idle(3, 16'd0);

        // Colour bars, enable dropped at clock 50: frame completes, then idle
        pattern_sel = 2'd0;
        enable      = 1'b1;
        tick();
        run_frame(0, FRAME, 50, -1, 2'd0, 16'd0);
        for (int i = 0; i < IM_X * BPP; i++) begin
            check($sformatf("bar byte %0d", i), 16'(cap[i]), 16'(BAR_LINE[i]));
        end
        check("bars href pulses", 16'(href_pulses), 16'(IM_Y));
        check("bars href cycles", 16'(href_cycles), 16'(IM_Y * IM_X * BPP));
        check_idle(2 * FRAME / 5, 16'd1);

        // Three back-to-back frames with mid-frame pattern_sel changes
        p1 = 2;
        p2 = $urandom_range(0, 3);
        p3 = (p2 + 1 + $urandom_range(0, 2)) % 4;
        pattern_sel = 2'(p1);
        enable      = 1'b1;
        tick();
        run_frame(p1, FRAME, -1, 70 + $urandom_range(0, 40), 2'(p2), 16'd1);
        check("counter y3x5 hi", 16'(ref_pix(2, 5, 3, 16'd1) >> 8), 16'h0003);
        check("f1 href pulses", 16'(href_pulses), 16'(IM_Y));
        tick();
        run_frame(p2, FRAME, -1, 30 + $urandom_range(0, 100), 2'(p3), 16'd2);
        check("f2 href pulses", 16'(href_pulses), 16'(IM_Y));
        tick();
        run_frame(p3, FRAME, 100, 20, 2'((p3 + 1) % 4), 16'd3);
        check("f3 href cycles", 16'(href_cycles), 16'(IM_Y * IM_X * BPP));
        check_idle(25, 16'd4);

        // Asynchronous reset during active line 2
        pattern_sel = 2'($urandom_range(0, 3));
        p1 = int'(pattern_sel);
        enable = 1'b1;
        tick();
        rs = (VSYNC_LEN + V_BACK + 2) * LP + $urandom_range(0, LP - 1);
        run_frame(p1, rs + 1, -1, -1, 2'd0, 16'd4);
        #1;
        rst_n_cam = 1'b0;
        #1;
        check("async VSYNC_cam", 16'(VSYNC_cam), 16'd0);
        check("async HREF_cam", 16'(HREF_cam), 16'd0);
        check("async data_cam", 16'(data_cam), 16'd0);
        check("async frame_done", 16'(frame_done), 16'd0);
        check("async frame_cnt", frame_cnt, 16'd0);
        tick();
        tick();
        check("held rst VSYNC_cam", 16'(VSYNC_cam), 16'd0);
        rst_n_cam   = 1'b1;
        pattern_sel = 2'd1;
        tick();
        run_frame(1, FRAME, 0, -1, 2'd0, 16'd0);
        check_idle(5, 16'd1);

        // Checkerboard frame after one completed frame (stamp 0001 when enabled)
        pattern_sel = 2'd3;
        enable      = 1'b1;
        tick();
        run_frame(3, FRAME, 10, -1, 2'd0, 16'd1);
`ifdef CAM_EMU_FRAME_STAMP_EN
        check("stamp byte0", 16'(cap[0]), 16'h0000);
        check("stamp byte1", 16'(cap[1]), 16'h0001);
`else
        check("checker byte0", 16'(cap[0]), 16'h0000);
        check("checker byte1", 16'(cap[1]), 16'h0000);
`endif
        check_idle(5, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
